// File: rtl/alu_seq_if.sv
// Handshake bundle between the CPU control path and the sequential ALU.
// The slave side is the ALU; the master side is the issuing/consuming stage.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, aluop, out_ready,
        input  in_ready, out_valid, c, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, aluop, out_ready,
        output in_ready, out_valid, c, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply (shift-add) and divide/remainder (restoring).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    alu_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_LUI  = 4'b0101;
    localparam logic [3:0] OP_EQB  = 4'b0110;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // product, or partial remainder
    logic [WIDTH-1:0] opa_q, opa_d;   // shifting multiplicand, or dividend/quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // shifting multiplier, or fixed divisor
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] sum, dif, res;
    logic             res_ovf, iter_op;
    logic [WIDTH-1:0] mul_acc, mul_opa, mul_opb;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc, div_quo, step_res;

    // Single-cycle datapath on the live bus operands
    always_comb begin
        sum     = bus.a + bus.b;
        dif     = bus.a - bus.b;
        res     = bus.b;
        res_ovf = 1'b0;
        iter_op = (bus.aluop == OP_MULU) || (bus.aluop == OP_DIVU) ||
                  (bus.aluop == OP_REMU);
        case (bus.aluop)
            OP_ADD: begin
                res     = sum;
                res_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res     = dif;
                res_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_LUI:  res = bus.b << (WIDTH/2);
            OP_EQB:  res = bus.b;
            default: res = bus.b;
        endcase
    end

    // One iteration step; divide by zero falls out naturally (quotient all
    // ones, remainder equals dividend) because every trial subtract succeeds.
    always_comb begin
        mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
        mul_opa   = opa_q << 1;
        mul_opb   = opb_q >> 1;
        div_shift = {acc_q, opa_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = ~div_trial[WIDTH+1];
        div_acc   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {opa_q[WIDTH-2:0], div_ge};
        case (op_q)
            OP_MULU: step_res = mul_acc;
            OP_DIVU: step_res = div_quo;
            default: step_res = div_acc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.aluop;
                    if (iter_op) begin
                        acc_d   = '0;
                        opa_d   = bus.a;
                        opb_d   = bus.b;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = BUSY;
                    end else begin
                        c_d     = res;
                        zero_d  = (res == '0);
                        ovf_d   = res_ovf;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OP_MULU) begin
                    acc_d = mul_acc;
                    opa_d = mul_opa;
                    opb_d = mul_opb;
                end else begin
                    acc_d = div_acc;
                    opa_d = div_quo;
                end
                if (cnt_q == CNT_W'(1)) begin
                    c_d     = step_res;
                    zero_d  = (step_res == '0);
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule
